// File: rtl/irq_pender.sv
// Interrupt pend source for the CLIC: synchronizes external lines, detects edge/level
// events, keeps per-source pending flags and offers them round-robin on a valid/ack port.
module irq_pender #(
    parameter int unsigned         NumSrc   = 8,
    parameter int unsigned         SrcBase  = 1,
    parameter int unsigned         VecWidth = 4,
    parameter logic [NumSrc-1:0]   EdgeMask = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NumSrc-1:0]   ext_irq,
    input  logic [NumSrc-1:0]   src_enable,
    output logic                pend_valid,
    output logic [VecWidth-1:0] pend_index,
    input  logic                pend_ack,
    output logic [NumSrc-1:0]   pending_out,
    output logic [NumSrc-1:0]   overrun_out,
    input  logic                overrun_clear,
    output logic [7:0]          overrun_count
);

    localparam int unsigned SelW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

    state_e              state_q, state_d;
    logic [NumSrc-1:0]   sync1_q, sync1_d;
    logic [NumSrc-1:0]   sync2_q, sync2_d;
    logic [NumSrc-1:0]   prev_q, prev_d;
    logic [NumSrc-1:0]   pending_q, pending_d;
    logic [NumSrc-1:0]   overrun_q, overrun_d;
    logic [7:0]          count_q, count_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic [SelW-1:0]     ptr_q, ptr_d;
    logic [VecWidth-1:0] index_q, index_d;

    logic [NumSrc-1:0]   evt;
    logic [NumSrc-1:0]   clr;
    logic [NumSrc-1:0]   ovr_hit;
    logic [SelW-1:0]     pick;
    logic                found;
    int unsigned         pos;

    // Event detection, pending/overrun bookkeeping
    always_comb begin
        sync1_d = ext_irq;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        evt     = '0;
        clr     = '0;
        for (int i = 0; i < NumSrc; i++) begin
            evt[i] = EdgeMask[i] ? (sync2_q[i] & ~prev_q[i] & src_enable[i])
                                 : (sync2_q[i] & src_enable[i]);
            clr[i] = (state_q == OFFER) && pend_ack && (sel_q == SelW'(i));
        end
        // A new event wins over the ack clear, so the source is offered again.
        pending_d = evt | (pending_q & ~clr);
        ovr_hit   = evt & pending_q & ~clr & EdgeMask;
        overrun_d = overrun_clear ? '0 : (overrun_q | ovr_hit);
        count_d   = count_q;
        if (overrun_clear) begin
            count_d = '0;
        end else if ((|ovr_hit) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Round-robin pick: first pending source at or after the pointer.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        pos   = 0;
        for (int k = 0; k < NumSrc; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NumSrc) begin
                pos = pos - NumSrc;
            end
            if (!found && pending_q[SelW'(pos)]) begin
                found = 1'b1;
                pick  = SelW'(pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        index_d = index_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    index_d = VecWidth'(SrcBase + int'(pick));
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (pend_ack) begin
                    ptr_d   = (int'(sel_q) == NumSrc - 1) ? '0 : sel_q + SelW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every flop, including the synchronizer stages, is reset asynchronously and
    // updated only with non-blocking assignments so all state advances on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            index_q   <= index_d;
        end
    end

    assign pend_valid    = (state_q == OFFER);
    assign pend_index    = index_q;
    assign pending_out   = pending_q;
    assign overrun_out   = overrun_q;
    assign overrun_count = count_q;

endmodule
